// File: rtl/test_monitor.sv
// test_monitor: end-of-test monitor snooping data-memory stores for TOHOST/CONSOLE, with counters and watchdogs
//   in  clk, reset (async active-low), mem_we, mem_addr[31:0], mem_wdata[31:0], retire
//   out done, pass, end_reason[1:0], fail_code[30:0], cycle_count, instret_count, console_valid, console_char[7:0]
module test_monitor #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned STALL_CYCLES = 1000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic             retire,
    output logic             done,
    output logic             pass,
    output logic [1:0]       end_reason,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
    output logic             console_valid,
    output logic [7:0]       console_char
);
    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;
    state_t state_q, state_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
    logic [31:0] stall_q, stall_d;
    logic console_valid_q, console_valid_d;
    logic [7:0] console_char_q, console_char_d;
    logic run, tohost;
    always_comb begin
        state_d         = state_q;
        fail_code_d     = fail_code_q;
        cycle_d         = cycle_q;
        instret_d       = instret_q;
        stall_d         = stall_q;
        console_valid_d = 1'b0;
        console_char_d  = console_char_q;
        run             = state_q == S_RUN;
        // only odd TOHOST values end the test; even values are ignored
        tohost          = mem_we && mem_addr == TOHOST_ADDR && mem_wdata[0];
        if (run) begin
            stall_d   = retire ? 32'd0 : stall_q + 1'b1;
            cycle_d   = &cycle_q ? cycle_q : cycle_q + 1'b1;
            instret_d = (retire && !(&instret_q)) ? instret_q + 1'b1 : instret_q;
            if (mem_we && mem_addr == CONSOLE_ADDR) begin
                console_valid_d = 1'b1;
                console_char_d  = mem_wdata[7:0];
            end
            // a TOHOST verdict on the same edge beats either watchdog
            if (tohost) begin
                state_d     = (mem_wdata == 32'd1) ? S_PASS : S_FAIL;
                fail_code_d = (mem_wdata == 32'd1) ? fail_code_q : mem_wdata[31:1];
            end else if (cycle_q == CNT_W'(MAX_CYCLES - 1) || stall_d == 32'(STALL_CYCLES)) begin
                state_d = S_TIMEOUT;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_RUN;
            fail_code_q     <= '0;
            cycle_q         <= '0;
            instret_q       <= '0;
            stall_q         <= '0;
            console_valid_q <= 1'b0;
            console_char_q  <= '0;
        end else begin
            state_q         <= state_d;
            fail_code_q     <= fail_code_d;
            cycle_q         <= cycle_d;
            instret_q       <= instret_d;
            stall_q         <= stall_d;
            console_valid_q <= console_valid_d;
            console_char_q  <= console_char_d;
        end
    end
    assign done          = state_q != S_RUN;
    assign pass          = state_q == S_PASS;
    assign end_reason    = state_q;
    assign fail_code     = fail_code_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
    assign console_valid = console_valid_q;
    assign console_char  = console_char_q;
endmodule
